pkt_serializer: RTL

Parametrised, clocked packetizer for the SP2NOC network interface. It accepts one bus write per valid/ready handshake and builds a packet of SRC_ADDR, destination address, sequence number, size, flags and data. The sequence number comes from an internal counter. The packet is emitted MSB-first as a stream of FLIT_W-bit flits with head/tail markers and per-flit valid/ready flow control. It sits between the bus-slave front end and the router local input port.

---
 rtl/pkt_serializer.sv | 97 +++++++++
 1 files changed

// File: rtl/pkt_serializer.sv
// Packetizer: latches {src, dst, seq, size, flags, data} per accepted request and streams it MSB-first as FLIT_W flits.
// Head flit appears the cycle after accept; flits hold while out_ready is low; in_ready reopens on tail consume for zero-bubble back-to-back.
module pkt_serializer #(
  parameter logic [15:0] SRC_ADDR = 16'h0000,
  parameter int          DATA_W   = 32,
  parameter int          FLIT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_addr,
  input  logic [2:0]        in_size,
  input  logic [7:0]        in_flags,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_head,
  output logic              out_tail,
  output logic [15:0]       seq_cnt
);

  localparam int PKT_W  = 64 + DATA_W;
  localparam int NFLITS = (PKT_W + FLIT_W - 1) / FLIT_W;
  localparam int PAD_W  = NFLITS * FLIT_W;
  localparam int IDX_W  = (NFLITS > 1) ? $clog2(NFLITS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFLITS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] seq;
    logic [4:0]  rsvd;
    logic [2:0]  size;
    logic [7:0]  flags;
  } hdr_t;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [PAD_W-1:0] img;
  logic [PAD_W-1:0] img_next;
  hdr_t             hdr;
  logic             last;
  logic             accept;

  assign last   = (idx == LAST_IDX);
  assign accept = in_valid && in_ready;

  assign in_ready = !rst && ((state == IDLE) || ((state == SEND) && last && out_ready));

  // Image is left-aligned so any padding lands in the low bits of the tail flit.
  always_comb begin
    hdr       = '0;
    hdr.src   = SRC_ADDR;
    hdr.dst   = in_addr;
    hdr.seq   = seq_cnt;
    hdr.size  = in_size;
    hdr.flags = in_flags;
    img_next  = '0;
    img_next[PAD_W-1 -: PKT_W] = {hdr, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      img     <= '0;
      seq_cnt <= 16'h0000;
    end else if (accept) begin
      state   <= SEND;
      idx     <= '0;
      img     <= img_next;
      seq_cnt <= seq_cnt + 16'd1;
    end else if ((state == SEND) && out_ready) begin
      if (last) begin
        state <= IDLE;
        idx   <= '0;
        img   <= '0;
      end else begin
        idx <= idx + 1'b1;
        img <= img << FLIT_W;
      end
    end
  end

  // The current flit always sits at the top of the shift register, so out_flit comes straight from flops.
  assign out_flit  = img[PAD_W-1 -: FLIT_W];
  assign out_valid = (state == SEND);
  assign out_head  = (state == SEND) && (idx == '0);
  assign out_tail  = (state == SEND) && last;

endmodule
